// File: rtl/clk_strobe_gen.sv
// ---------------------------------------------------------------------------
// clk_strobe_gen
//
// Multi-channel clock-enable generator running entirely on refclk. Each
// channel owns a fractional phase accumulator; the carry out of the
// accumulator becomes a one-cycle enable strobe and the accumulator MSB a
// ~50 % duty square-wave level. A two-state lock FSM emulates PLL lock: it
// drops on every accepted configuration write and reasserts after
// LOCK_CYCLES refclk edges. Both per-channel outputs are gated by locked.
//
// Optional feature macro: CLK_STROBE_PHASE_ALIGN_EN
//   defined   - a valid write zeroes the accumulator of every other channel
//               and clears all carry/MSB flags, so channel phase
//               relationships are deterministic after reconfiguration.
//   undefined - only the addressed channel is touched.
//
// Parameters:
//   NUM_CH      number of channels (1..8)
//   ACC_W       accumulator / increment width (16..32)
//   LOCK_CYCLES settle edges before locked asserts (>= 2)
//   DEF_INC     reset increment of every channel (default: half refclk rate)
//
// Ports:
//   refclk     in   single clock
//   rst        in   asynchronous active-high reset
//   cfg_we     in   one-cycle configuration write strobe
//   cfg_ch     in   target channel of the write
//   cfg_inc    in   new increment for the target channel
//   cfg_phase  in   accumulator load value for the target channel
//   outclk_en  out  per-channel one-cycle enable strobe
//   outclk     out  per-channel square-wave level (accumulator MSB)
//   locked     out  all channels settled
// ---------------------------------------------------------------------------
module clk_strobe_gen #(
  parameter int unsigned      NUM_CH      = 2,
  parameter int unsigned      ACC_W       = 32,
  parameter int unsigned      LOCK_CYCLES = 16,
  parameter logic [ACC_W-1:0] DEF_INC     = {1'b1, {(ACC_W-1){1'b0}}},
  localparam int unsigned     CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [ACC_W-1:0]  cfg_phase,
  output logic [NUM_CH-1:0] outclk_en,
  output logic [NUM_CH-1:0] outclk,
  output logic              locked
);

  localparam int unsigned      CNT_W    = $clog2(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOCK_CYCLES - 1);

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_t;

  lock_state_t      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             wr_valid;

  // A write to a channel index beyond NUM_CH is dropped entirely. The
  // compare is one bit wider so NUM_CH = 2^CH_W cannot wrap to zero.
  assign wr_valid = cfg_we && ({1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH));

  // Lock emulation: any accepted write restarts the full settle period,
  // and wins over the final settle count.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q <= ST_SETTLE;
      cnt_q   <= CNT_INIT;
      locked  <= 1'b0;
    end else if (wr_valid) begin
      state_q <= ST_SETTLE;
      cnt_q   <= CNT_INIT;
      locked  <= 1'b0;
    end else begin
      case (state_q)
        ST_SETTLE: begin
          if (cnt_q == '0) begin
            state_q <= ST_LOCKED;
            locked  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_LOCKED: begin
          locked <= 1'b1;
        end
        default: begin
          state_q <= ST_SETTLE;
          cnt_q   <= CNT_INIT;
          locked  <= 1'b0;
        end
      endcase
    end
  end

  // Per-channel phase accumulators.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] inc_q;
    logic             carry_q;
    logic             msb_q;
    logic [ACC_W:0]   sum;
    logic             sel;
    logic             clr;

    assign sum = {1'b0, acc_q} + {1'b0, inc_q};
    assign sel = wr_valid && (cfg_ch == CH_W'(i));

`ifdef CLK_STROBE_PHASE_ALIGN_EN
    // Realign every non-addressed channel to phase zero on any write.
    assign clr = wr_valid;
`else
    assign clr = 1'b0;
`endif

    // The loaded phase replaces this cycle's sum; flags restart from zero.
    always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
        acc_q   <= '0;
        inc_q   <= DEF_INC;
        carry_q <= 1'b0;
        msb_q   <= 1'b0;
      end else if (sel) begin
        inc_q   <= cfg_inc;
        acc_q   <= cfg_phase;
        carry_q <= 1'b0;
        msb_q   <= 1'b0;
      end else if (clr) begin
        acc_q   <= '0;
        carry_q <= 1'b0;
        msb_q   <= 1'b0;
      end else begin
        acc_q   <= sum[ACC_W-1:0];
        carry_q <= sum[ACC_W];
        msb_q   <= sum[ACC_W-1];
      end
    end

    // Gate of two flops: outputs fall with locked and with async reset.
    assign outclk_en[i] = carry_q & locked;
    assign outclk[i]    = msb_q & locked;
  end

endmodule

// File: tb/tb_clk_strobe_gen.sv
module tb_clk_strobe_gen;

  localparam int unsigned NUM_CH      = 3;
  localparam int unsigned ACC_W       = 32;
  localparam int unsigned LOCK_CYCLES = 16;

  logic              refclk = 1'b0;
  logic              rst;
  logic              cfg_we;
  logic [1:0]        cfg_ch;
  logic [ACC_W-1:0]  cfg_inc;
  logic [ACC_W-1:0]  cfg_phase;
  logic [NUM_CH-1:0] outclk_en;
  logic [NUM_CH-1:0] outclk;
  logic              locked;

  clk_strobe_gen #(
    .NUM_CH      (NUM_CH),
    .ACC_W       (ACC_W),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_inc   (cfg_inc),
    .cfg_phase (cfg_phase),
    .outclk_en (outclk_en),
    .outclk    (outclk),
    .locked    (locked)
  );

  always #5 refclk = ~refclk;

  typedef struct packed {
    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] lvl;
    logic              lk;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model of the behaviour seen at the outputs.
  logic [ACC_W-1:0]  m_acc [NUM_CH];
  logic [ACC_W-1:0]  m_inc [NUM_CH];
  logic [NUM_CH-1:0] m_carry;
  logic [NUM_CH-1:0] m_msb;
  logic              m_locked;
  int                m_cnt;

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_acc[i] = '0;
      m_inc[i] = 32'h8000_0000;
    end
    m_carry  = '0;
    m_msb    = '0;
    m_locked = 1'b0;
    m_cnt    = LOCK_CYCLES - 1;
  endtask

  task automatic model_edge(input logic we, input logic [1:0] ch,
                            input logic [ACC_W-1:0] inc, input logic [ACC_W-1:0] ph);
    logic           wr;
    logic [ACC_W:0] s;
    wr = we && (int'(ch) < NUM_CH);
    for (int i = 0; i < NUM_CH; i++) begin
      s = {1'b0, m_acc[i]} + {1'b0, m_inc[i]};
      if (wr && int'(ch) == i) begin
        m_inc[i] = inc;
        m_acc[i] = ph;
        m_carry[i] = 1'b0;
        m_msb[i] = 1'b0;
      end
`ifdef CLK_STROBE_PHASE_ALIGN_EN
      else if (wr) begin
        m_acc[i] = '0;
        m_carry[i] = 1'b0;
        m_msb[i] = 1'b0;
      end
`endif
      else begin
        m_acc[i] = s[ACC_W-1:0];
        m_carry[i] = s[ACC_W];
        m_msb[i] = s[ACC_W-1];
      end
    end
    if (wr) begin
      m_locked = 1'b0;
      m_cnt    = LOCK_CYCLES - 1;
    end else if (!m_locked) begin
      if (m_cnt == 0) m_locked = 1'b1;
      else m_cnt--;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.en  = m_carry & {NUM_CH{m_locked}};
    e.lvl = m_msb & {NUM_CH{m_locked}};
    e.lk  = m_locked;
    return e;
  endfunction

  function automatic void check(input string tag, input int obs, input int exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endfunction

  // One refclk cycle: drive, predict, clock, compare against scoreboard.
  task automatic cyc(input logic we, input logic [1:0] ch,
                     input logic [ACC_W-1:0] inc, input logic [ACC_W-1:0] ph);
    exp_t e;
    exp_t o;
    cfg_we    = we;
    cfg_ch    = ch;
    cfg_inc   = inc;
    cfg_phase = ph;
    model_edge(we, ch, inc, ph);
    sb.push_back(model_out());
    @(posedge refclk);
    #1;
    cfg_we = 1'b0;
    e = sb.pop_front();
    o = {outclk_en, outclk, locked};
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL sb: observed %h expected %h", o, e);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 2'd0, '0, '0);
  endtask

  task automatic wait_lock(output int k);
    k = 0;
    while (!locked && k < 40) begin
      idle(1);
      k++;
    end
  endtask

  initial begin
    int k;
    int c0;
    int c1;
    int h0;
    int tg;
    int adj;
    int opp;
    logic prev;

    rst = 1'b1;
    cfg_we = 1'b0;
    cfg_ch = '0;
    cfg_inc = '0;
    cfg_phase = '0;
    model_reset();
    #12;
    check("rst_en", int'(outclk_en), 0);
    check("rst_lvl", int'(outclk), 0);
    check("rst_locked", int'(locked), 0);
    rst = 1'b0;

    // Default reset sequence
    wait_lock(k);
    check("lock_after_rst", k, 16);
    c0 = 0; c1 = 0; tg = 0; prev = outclk[0];
    for (int n = 0; n < 20; n++) begin
      idle(1);
      c0 += int'(outclk_en[0]);
      c1 += int'(outclk_en[1]);
      if (outclk[0] != prev) tg++;
      prev = outclk[0];
    end
    check("def_en0", c0, 10);
    check("def_en1", c1, 10);
    check("def_toggle0", tg, 20);

    // Reprogram ch0 to quarter rate
    cyc(1'b1, 2'd0, 32'h4000_0000, 32'h0);
    check("wr_drops_lock", int'(locked), 0);
    wait_lock(k);
    check("lock_after_wr", k, 16);
    c0 = 0; c1 = 0; h0 = 0;
    for (int n = 0; n < 20; n++) begin
      idle(1);
      c0 += int'(outclk_en[0]);
      c1 += int'(outclk_en[1]);
      h0 += int'(outclk[0]);
    end
    check("q_en0", c0, 5);
    check("q_high0", h0, 10);
    check("q_en1", c1, 10);

    // Fractional rate on ch1
    cyc(1'b1, 2'd1, 32'h3333_3333, 32'h0);
    wait_lock(k);
    check("lock_frac", k, 16);
    c1 = 0; adj = 0; prev = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      idle(1);
      c1 += int'(outclk_en[1]);
      if (outclk_en[1] && prev) adj++;
      prev = outclk_en[1];
    end
    check("frac_cnt_ok", int'(c1 >= 199 && c1 <= 200), 1);
    check("frac_adjacent", adj, 0);

    // Write during settle restarts the count
    cyc(1'b1, 2'd0, 32'h4000_0000, 32'h0);
    idle(4);
    cyc(1'b1, 2'd0, 32'h4000_0000, 32'h0);
    wait_lock(k);
    check("lock_restart", k, 16);

    // Invalid channel is ignored
    cyc(1'b1, 2'd3, 32'h0000_1234, 32'hFFFF_FFFF);
    check("inv_locked", int'(locked), 1);
    c0 = 0; k = 0;
    for (int n = 0; n < 20; n++) begin
      idle(1);
      c0 += int'(outclk_en[0]);
      k  += int'(!locked);
    end
    check("inv_unlocked_cycles", k, 0);
    check("inv_en0", c0, 5);

    // Stop ch0
    cyc(1'b1, 2'd0, 32'h0, 32'h0);
    wait_lock(k);
    check("lock_stop", k, 16);
    c0 = 0; h0 = 0;
    for (int n = 0; n < 40; n++) begin
      idle(1);
      c0 += int'(outclk_en[0]);
      h0 += int'(outclk[0]);
    end
    check("stop_en0", c0, 0);
    check("stop_high0", h0, 0);

    // Asynchronous reset mid-stream
    check("pre_rst_locked", int'(locked), 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_en", int'(outclk_en), 0);
    check("arst_lvl", int'(outclk), 0);
    check("arst_locked", int'(locked), 0);
    model_reset();
    @(posedge refclk);
    #1;
    check("arst_hold_locked", int'(locked), 0);
    rst = 1'b0;
    wait_lock(k);
    check("lock_after_arst", k, 16);
    c0 = 0; c1 = 0;
    for (int n = 0; n < 20; n++) begin
      idle(1);
      c0 += int'(outclk_en[0]);
      c1 += int'(outclk_en[1]);
    end
    check("post_rst_en0", c0, 10);
    check("post_rst_en1", c1, 10);

    // Phase write on ch0
    cyc(1'b1, 2'd0, 32'h8000_0000, 32'h8000_0000);
    wait_lock(k);
    check("lock_phase", k, 16);
    c0 = 0; c1 = 0; opp = 0;
    for (int n = 0; n < 10; n++) begin
      idle(1);
      c0 += int'(outclk_en[0]);
      c1 += int'(outclk_en[1]);
      opp += int'(outclk_en[0] != outclk_en[1]);
    end
    check("ph_en0", c0, 5);
    check("ph_en1", c1, 5);
`ifdef CLK_STROBE_PHASE_ALIGN_EN
    check("ph_opposite", opp, 10);
`endif

    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
